servo_sweep_sequencer: RTL

- Upstream stimulus stage for the servo controller. Drives its `channelselect`, `duty` and `latchbtn` inputs directly.
- On each sweep tick, computes the next point of a triangle duty sweep, then latches that duty into every channel in turn.
- Used for bring-up and demo sweeps without the DE1-SoC switches and key.

---
 rtl/servo_pkg.sv | 11 +
 rtl/servo_sweep_sequencer_if.sv | 24 ++
 rtl/sweep_tick_gen.sv | 42 ++++
 rtl/servo_sweep_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and FSM state type for the servo sweep stimulus generator.
package servo_pkg;

  localparam int BASE_CLOCK       = 50_000_000;
  localparam int DUTY_W           = 8;
  localparam int SWEEP_TICK_HZ    = 100;
  localparam int TICK_DIV_DEFAULT = BASE_CLOCK / SWEEP_TICK_HZ;

  typedef enum logic [2:0] {IDLE, STEP, SETUP, LATCH, RELEASE} sweep_state_t;

endpackage

// File: rtl/servo_sweep_sequencer_if.sv
// Sequencer-to-servo-controller signal bundle; master is the sequencer side.
interface servo_sweep_sequencer_if
  import servo_pkg::*;
#(
  parameter int CHSEL_W = 2
);
  logic               enable;
  logic [CHSEL_W-1:0] channelselect;
  logic [DUTY_W-1:0]  duty;
  logic               latchbtn;
  logic               busy;
  logic               sweep_dir;
  logic               overrun;

  modport master (
    input  enable,
    output channelselect, duty, latchbtn, busy, sweep_dir, overrun
  );

  modport slave (
    output enable,
    input  channelselect, duty, latchbtn, busy, sweep_dir, overrun
  );
endinterface

// File: rtl/sweep_tick_gen.sv
// Sweep tick divider with a single-entry pending flag and sticky overrun.
module sweep_tick_gen
  import servo_pkg::*;
#(
  parameter int tick_div = TICK_DIV_DEFAULT
)(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic take,
  output logic pending,
  output logic overrun
);
  localparam int CW = (tick_div > 1) ? $clog2(tick_div) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_pending;
  logic          r_overrun;
  logic          w_tick;

  assign w_tick = enable && (r_cnt == CW'(tick_div - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!enable || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;

      // A tick coinciding with take re-arms the flag rather than overrunning.
      if (w_tick)    r_pending <= 1'b1;
      else if (take) r_pending <= 1'b0;

      if (w_tick && r_pending && !take) r_overrun <= 1'b1;
    end
  end

  assign pending = r_pending;
  assign overrun = r_overrun;
endmodule

// File: rtl/servo_sweep_sequencer.sv
// Triangle duty sweep written to every servo channel on each tick.
// Optional endpoint dwell is enabled by defining SERVO_SWEEP_DWELL_EN.
module servo_sweep_sequencer
  import servo_pkg::*;
#(
  parameter int              channels          = 4,
  parameter int              channelselectbits = (channels > 1) ? $clog2(channels) : 1,
  parameter logic [DUTY_W-1:0] duty_min        = 8'd0,
  parameter logic [DUTY_W-1:0] duty_max        = 8'd255,
  parameter logic [DUTY_W-1:0] duty_step       = 8'd1,
  parameter int              tick_div          = TICK_DIV_DEFAULT,
  parameter int              latch_hold        = 4
`ifdef SERVO_SWEEP_DWELL_EN
  , parameter int            dwell_ticks       = 50
`endif
)(
  input  logic clock,
  input  logic reset,
  servo_sweep_sequencer_if.master bus
);
  // state   | meaning
  // IDLE    | waiting for a pending tick, latchbtn high
  // STEP    | advance duty/direction, restart at channel 0
  // SETUP   | present channelselect with latchbtn high
  // LATCH   | latchbtn low for latch_hold cycles
  // RELEASE | latchbtn high before the channel may change

  localparam int HW = (latch_hold > 1) ? $clog2(latch_hold) : 1;

  sweep_state_t                 r_state, w_state_nxt;
  logic [channelselectbits-1:0] r_ch, w_ch_nxt;
  logic [DUTY_W-1:0]            r_duty, w_duty_nxt;
  logic                         r_dir, w_dir_nxt;
  logic [HW-1:0]                r_hold, w_hold_nxt;
  logic                         w_take, w_pending, w_overrun;
  logic [DUTY_W:0]              w_sum, w_floor;

`ifdef SERVO_SWEEP_DWELL_EN
  localparam int DWW = $clog2(dwell_ticks + 1);
  logic [DWW-1:0] r_dwell, w_dwell_nxt;
`endif

  sweep_tick_gen #(.tick_div(tick_div)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .enable  (bus.enable),
    .take    (w_take),
    .pending (w_pending),
    .overrun (w_overrun)
  );

  // Nine-bit sums keep the endpoint compares free of wrap-around.
  assign w_sum   = {1'b0, r_duty}   + {1'b0, duty_step};
  assign w_floor = {1'b0, duty_min} + {1'b0, duty_step};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_duty  <= duty_min;
      r_dir   <= 1'b1;
      r_hold  <= '0;
`ifdef SERVO_SWEEP_DWELL_EN
      r_dwell <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_duty  <= w_duty_nxt;
      r_dir   <= w_dir_nxt;
      r_hold  <= w_hold_nxt;
`ifdef SERVO_SWEEP_DWELL_EN
      r_dwell <= w_dwell_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_hold_nxt  = r_hold;
    w_take      = 1'b0;
`ifdef SERVO_SWEEP_DWELL_EN
    w_dwell_nxt = r_dwell;
`endif
    case (r_state)
      IDLE: begin
        if (w_pending && bus.enable) begin
          w_take = 1'b1;
`ifdef SERVO_SWEEP_DWELL_EN
          if (r_dwell != '0) w_dwell_nxt = r_dwell - 1'b1;
          else               w_state_nxt = STEP;
`else
          w_state_nxt = STEP;
`endif
        end
      end
      STEP: begin
        w_ch_nxt    = '0;
        w_state_nxt = SETUP;
        if (r_dir) begin
          if (w_sum >= {1'b0, duty_max}) begin
            w_duty_nxt = duty_max;
            w_dir_nxt  = 1'b0;
`ifdef SERVO_SWEEP_DWELL_EN
            w_dwell_nxt = DWW'(dwell_ticks);
`endif
          end else begin
            w_duty_nxt = w_sum[DUTY_W-1:0];
          end
        end else begin
          if ({1'b0, r_duty} <= w_floor) begin
            w_duty_nxt = duty_min;
            w_dir_nxt  = 1'b1;
`ifdef SERVO_SWEEP_DWELL_EN
            w_dwell_nxt = DWW'(dwell_ticks);
`endif
          end else begin
            w_duty_nxt = r_duty - duty_step;
          end
        end
      end
      SETUP: begin
        w_hold_nxt  = HW'(latch_hold - 1);
        w_state_nxt = LATCH;
      end
      LATCH: begin
        if (r_hold == '0) w_state_nxt = RELEASE;
        else              w_hold_nxt  = r_hold - 1'b1;
      end
      RELEASE: begin
        if ((r_ch == channelselectbits'(channels - 1)) || !bus.enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_ch_nxt    = r_ch + 1'b1;
          w_state_nxt = SETUP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.channelselect = r_ch;
  assign bus.duty          = r_duty;
  assign bus.latchbtn      = (r_state != LATCH);
  assign bus.busy          = (r_state == SETUP) || (r_state == LATCH) || (r_state == RELEASE);
  assign bus.sweep_dir     = r_dir;
  assign bus.overrun       = w_overrun;
endmodule
